// File: rtl/ternary_pkg.sv
// ternary_pkg
// Shared definitions for the trit-serial sequencer and its op unit.
// Trit codes: 00 = 0, 01 = 1, 10 = 2, 11 = invalid.
// Opcodes: 00 MIN, 01 MAX, 10 ANY, 11 CONSENSUS.
// Sequencer states: IDLE (accepting), RUN (one trit per cycle), DONE (result held).
package ternary_pkg;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] TX = 2'b11;

  localparam logic [1:0] OP_MIN  = 2'b00;
  localparam logic [1:0] OP_MAX  = 2'b01;
  localparam logic [1:0] OP_ANY  = 2'b10;
  localparam logic [1:0] OP_CONS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ternary_op_unit.sv
// ternary_op_unit
// Combinational single-trit operator shared by the sequencer.
// Ports:
//   a, b    : input trits (2-bit codes)
//   op      : operation select (MIN / MAX / ANY / CONSENSUS)
//   y       : result trit; forced to 0 when either input is invalid
//   invalid : high when a or b carries the invalid code 11
module ternary_op_unit
  import ternary_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [1:0] y,
  output logic       invalid
);

  logic [1:0] min_t;
  logic [1:0] max_t;
  logic [1:0] any_t;
  logic [1:0] cons_t;
  logic [2:0] sum;

  // Each cell computes on the raw codes; the invalid case is masked afterwards,
  // so the cells never need to know about code 11 themselves.
  always_comb begin
    min_t  = (a < b) ? a : b;
    max_t  = (a < b) ? b : a;
    cons_t = (a == b) ? a : T1;

    // ANY is a+b-1 clamped into 0..2; with legal inputs the sum is 0..4.
    sum = {1'b0, a} + {1'b0, b};
    if (sum <= 3'd1) begin
      any_t = T0;
    end else if (sum >= 3'd3) begin
      any_t = T2;
    end else begin
      any_t = T1;
    end
  end

  always_comb begin
    invalid = (a == TX) || (b == TX);
    y       = T0;
    if (!invalid) begin
      case (op)
        OP_MIN:  y = min_t;
        OP_MAX:  y = max_t;
        OP_ANY:  y = any_t;
        default: y = cons_t;
      endcase
    end
  end

endmodule

// File: rtl/ternary_vector_sequencer.sv
// ternary_vector_sequencer
// Trit-serial controller: latches two N_TRITS-trit operands and an opcode,
// runs one shared op unit over them LSB trit first (one trit per cycle) and
// returns the assembled result through a valid/ready handshake.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : request handshake; in_ready high only in IDLE
//   in_op, in_a, in_b    : opcode and packed operands (trit i = bits [2i+1:2i])
//   out_valid/out_ready  : result handshake; out_valid high only in DONE
//   out_result, out_err  : result vector and sticky invalid-operand flag
//   busy                 : high in RUN or DONE
module ternary_vector_sequencer
  import ternary_pkg::*;
#(
  parameter int N_TRITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [2*N_TRITS-1:0] in_a,
  input  logic [2*N_TRITS-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N_TRITS-1:0] out_result,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(N_TRITS) + 1;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]     cnt;
  logic [2*N_TRITS-1:0] a_reg;
  logic [2*N_TRITS-1:0] b_reg;
  logic [1:0]           op_reg;
  logic [2*N_TRITS-1:0] res_reg;
  logic                 err_reg;

  logic [1:0] a_cur;
  logic [1:0] b_cur;
  logic [1:0] trit_y;
  logic       trit_inv;
  logic       last_trit;

  // The counter is wide enough to hold N_TRITS, so it never wraps; the RUN
  // exit is decided purely on the index of the trit being written.
  assign last_trit = (cnt == CNT_W'(N_TRITS - 1));

  // Trit mux feeding the shared op unit from the latched operands.
  always_comb begin
    a_cur = T0;
    b_cur = T0;
    for (int i = 0; i < N_TRITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_cur = a_reg[2*i +: 2];
        b_cur = b_reg[2*i +: 2];
      end
    end
  end

  ternary_op_unit u_op (
    .a       (a_cur),
    .b       (b_cur),
    .op      (op_reg),
    .y       (trit_y),
    .invalid (trit_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs are pure functions of state, so the result handshake
  // and the next accept can never overlap.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_trit) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Operands and op are captured only on accept, so requester-side changes
  // during RUN/DONE cannot disturb the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            op_reg  <= in_op;
            res_reg <= '0;
            err_reg <= 1'b0;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < N_TRITS; i++) begin
            if (cnt == CNT_W'(i)) begin
              res_reg[2*i +: 2] <= trit_y;
            end
          end
          err_reg <= err_reg | trit_inv;
          cnt     <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_result = res_reg;
  assign out_err    = err_reg;

endmodule
